// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - round-robin IF/LS arbiter onto a single AXI4-Lite master
module axi_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ack,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wstrb,
  output logic                  ls_ack,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, ACK} state_t;

  state_t state;
  logic   prio_if;
  logic   gnt_ls;
  logic   pick_ls;
  logic   aw_pend;
  logic   w_pend;
  logic   rd_err;
  logic   wr_err;

  // prio_if only breaks ties; a lone requester is granted without touching it
  assign pick_ls = ls_req && (!if_req || !prio_if);
  assign aw_pend = m_axi_awvalid && !m_axi_awready;
  assign w_pend  = m_axi_wvalid && !m_axi_wready;
  assign rd_err  = (m_axi_rresp == 2'b10) || (m_axi_rresp == 2'b11);
  assign wr_err  = (m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      prio_if       <= 1'b1;
      gnt_ls        <= 1'b0;
      if_ack        <= 1'b0;
      ls_ack        <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            if (if_req && ls_req) prio_if <= pick_ls;
            gnt_ls <= pick_ls;
            if (pick_ls && ls_we) begin
              m_axi_awaddr  <= ls_addr;
              m_axi_wdata   <= ls_wdata;
              m_axi_wstrb   <= ls_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_AW;
            end else begin
              m_axi_araddr  <= pick_ls ? ls_addr : if_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_A;
            end
          end
        end
        RD_A: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_D;
          end
        end
        RD_D: begin
          if (m_axi_rvalid) begin
            rsp_rdata    <= m_axi_rdata;
            rsp_err      <= rd_err;
            m_axi_rready <= 1'b0;
            if_ack       <= !gnt_ls;
            ls_ack       <= gnt_ls;
            state        <= ACK;
          end
        end
        WR_AW: begin
          // AW and W retire independently; B is accepted only once both are gone
          m_axi_awvalid <= aw_pend;
          m_axi_wvalid  <= w_pend;
          if (!aw_pend && !w_pend) begin
            m_axi_bready <= 1'b1;
            state        <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi_bvalid) begin
            rsp_err      <= wr_err;
            m_axi_bready <= 1'b0;
            if_ack       <= !gnt_ls;
            ls_ack       <= gnt_ls;
            state        <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - directed vector bench for axi_mem_arbiter
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, ls_req, ls_we, ls_ack;
  logic [31:0] if_addr, ls_addr, ls_wdata, rsp_rdata;
  logic [3:0]  ls_wstrb;
  logic        rsp_err;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ack(ls_ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // slave configuration
  int          ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0;
  logic [1:0]  resp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  // monitor state
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0;
  int          if_acks = 0, ls_acks = 0, b_hs = 0, viol = 0;
  logic        p_arvalid = 0, p_awvalid = 0, p_wvalid = 0, p_bready = 0;
  logic        p_if_ack = 0, p_ls_ack = 0;
  logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  // ready/valid values held here were the ones seen at the previous rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_arvalid && !arready && (!arvalid || araddr !== p_araddr)) viol++;
      if (p_awvalid && !awready && (!awvalid || awaddr !== p_awaddr)) viol++;
      if (p_wvalid && !wready && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) viol++;
      if (p_bready && bvalid) b_hs++;
      if ((p_if_ack && if_ack) || (p_ls_ack && ls_ack)) viol++;
      if (if_ack) if_acks++;
      if (ls_ack) ls_acks++;
    end
    arready = arvalid && (ar_cnt >= ar_dly);
    ar_cnt  = arvalid ? ar_cnt + 1 : 0;
    awready = awvalid && (aw_cnt >= aw_dly);
    aw_cnt  = awvalid ? aw_cnt + 1 : 0;
    wready  = wvalid && (w_cnt >= w_dly);
    w_cnt   = wvalid ? w_cnt + 1 : 0;
    rvalid  = rready && (r_cnt >= r_dly);
    r_cnt   = rready ? r_cnt + 1 : 0;
    rdata   = rdata_cfg;
    rresp   = resp_cfg;
    bvalid  = bready;
    bresp   = resp_cfg;
    p_arvalid = arvalid; p_araddr = araddr;
    p_awvalid = awvalid; p_awaddr = awaddr;
    p_wvalid  = wvalid;  p_wdata  = wdata; p_wstrb = wstrb;
    p_bready  = bready;  p_if_ack = if_ack; p_ls_ack = ls_ack;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [159:0] all_outs();
    return {if_ack, ls_ack, rsp_rdata, rsp_err, araddr, arvalid, rready, awaddr,
            awvalid, wdata, wstrb, wvalid, bready};
  endfunction

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [1:0]  resp;
    logic [31:0] rd;
    int          ard, awd, wd_dly, rd_dly;
    int          lat;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(bit is_ls, bit we, logic [31:0] addr, logic [31:0] wd,
                              logic [3:0] ws, logic [1:0] resp, logic [31:0] rd,
                              int ard, int awd, int wdl, int rdl, int lat,
                              logic [31:0] er, bit ee);
    vec_t v;
    v.is_ls = is_ls; v.we = we; v.addr = addr; v.wd = wd; v.ws = ws; v.resp = resp;
    v.rd = rd; v.ard = ard; v.awd = awd; v.wd_dly = wdl; v.rd_dly = rdl; v.lat = lat;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic tie(input bit exp_ls_first, input int idx);
    int first;
    int nacks;
    first = -1;
    nacks = 0;
    ar_dly = 0; r_dly = 0; resp_cfg = 2'b00; rdata_cfg = 32'hA5A5_0000 + idx;
    if_addr = 32'h400; ls_addr = 32'h500; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int n = 0; n < 40 && nacks < 2; n++) begin
      step();
      if (if_ack) begin if (first < 0) first = 0; if_req = 1'b0; nacks++; end
      if (ls_ack) begin if (first < 0) first = 1; ls_req = 1'b0; nacks++; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    check($sformatf("tie%0d_first_ls", idx), first, exp_ls_first ? 1 : 0);
    check($sformatf("tie%0d_acks", idx), nacks, 2);
    step();
  endtask

  vec_t vecs[9];

  initial begin
    int ia0, la0, b0, v0, lat;
    bit got;

    vecs[0] = mk(0, 0, 32'h0000_0100, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 0, 0, 0, 3, 32'hDEAD_BEEF, 0);
    vecs[1] = mk(1, 0, 32'h0000_0044, 0, 0, 2'b01, 32'hCAFE_F00D, 0, 0, 0, 0, 3, 32'hCAFE_F00D, 0);
    vecs[2] = mk(1, 1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 2'b00, 32'hFFFF_FFFF, 0, 3, 0, 0, 6, 32'hCAFE_F00D, 0);
    vecs[3] = mk(0, 0, 32'h0000_0200, 0, 0, 2'b10, 32'h1111_2222, 0, 0, 0, 0, 3, 32'h1111_2222, 1);
    vecs[4] = mk(1, 1, 32'h0000_3000, 32'h0BAD_F00D, 4'b1111, 2'b11, 32'hFFFF_FFFF, 0, 0, 2, 0, 5, 32'h1111_2222, 1);
    vecs[5] = mk(1, 1, 32'h0000_3004, 32'h0000_00AA, 4'b0001, 2'b01, 32'hFFFF_FFFF, 0, 0, 0, 0, 3, 32'h1111_2222, 0);
    vecs[6] = mk(0, 0, 32'h0000_0104, 0, 0, 2'b00, 32'h0A0B_0C0D, 10, 0, 0, 0, 13, 32'h0A0B_0C0D, 0);
    vecs[7] = mk(1, 0, 32'h0000_1003, 0, 0, 2'b11, 32'h55AA_55AA, 0, 0, 0, 0, 3, 32'h55AA_55AA, 1);
    vecs[8] = mk(1, 0, 32'h0000_0048, 0, 0, 2'b00, 32'h0000_0077, 0, 0, 0, 2, 5, 32'h0000_0077, 0);

    rst_n = 1'b0;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; awready = 0; wready = 0; bvalid = 0; bresp = '0;
    step();
    step();
    check("reset_outs", all_outs(), '0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      ar_dly = vecs[i].ard; aw_dly = vecs[i].awd; w_dly = vecs[i].wd_dly; r_dly = vecs[i].rd_dly;
      resp_cfg = vecs[i].resp; rdata_cfg = vecs[i].rd;
      ia0 = if_acks; la0 = ls_acks; b0 = b_hs; v0 = viol;
      if (vecs[i].is_ls) begin
        ls_we = vecs[i].we; ls_addr = vecs[i].addr; ls_wdata = vecs[i].wd; ls_wstrb = vecs[i].ws;
        ls_req = 1'b1;
      end else begin
        if_addr = vecs[i].addr;
        if_req = 1'b1;
      end
      got = 0;
      lat = 0;
      for (int n = 1; n <= 40 && !got; n++) begin
        step();
        if (n == 1) begin
          if (vecs[i].we)
            check($sformatf("v%0d_aw_w", i), {awvalid, wvalid, awaddr, wdata, wstrb, arvalid},
                  {2'b11, vecs[i].addr, vecs[i].wd, vecs[i].ws, 1'b0});
          else
            check($sformatf("v%0d_ar", i), {arvalid, araddr, awvalid, wvalid},
                  {1'b1, vecs[i].addr, 2'b00});
        end
        if (n == 2 && vecs[i].we)
          check($sformatf("v%0d_c2_valids", i), {awvalid, wvalid},
                {vecs[i].awd > 0, vecs[i].wd_dly > 0});
        if (vecs[i].is_ls ? ls_ack : if_ack) begin
          got = 1;
          lat = n;
        end
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), rsp_err, vecs[i].exp_err);
      step();
      check($sformatf("v%0d_ack_counts", i), {if_acks - ia0, ls_acks - la0},
            {vecs[i].is_ls ? 0 : 1, vecs[i].is_ls ? 1 : 0});
      check($sformatf("v%0d_b_handshakes", i), b_hs - b0, vecs[i].we ? 1 : 0);
      check($sformatf("v%0d_protocol", i), viol - v0, 0);
    end

    // round-robin: alternation only advances on ties
    for (int t = 0; t < 5; t++) tie(t % 2 == 1, t);

    // abort a read stuck in the data phase
    ar_dly = 0; r_dly = 20; resp_cfg = 2'b00; rdata_cfg = 32'h9999_9999;
    if_addr = 32'h300;
    if_req = 1'b1;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      step();
      if (rready) got = 1;
    end
    check("abort_reached_rd_d", got, 1);
    ia0 = if_acks;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async_outs", all_outs(), '0);
    if_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    r_dly = 0;
    step();
    step();
    check("abort_no_ack", if_acks - ia0, 0);
    tie(1'b0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
